// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry,
// derived address field widths and fill FSM state encoding.
package icache_direct_pkg;

   localparam int WORD_SIZE  = 16;
   localparam int LINE_WORDS = 4;
   localparam int NUM_LINES  = 8;

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
   localparam int LINE_W = WORD_SIZE - OFF_W;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } fill_state_t;

endpackage

// File: rtl/icache_direct_fill_ctrl.sv
// Line-fill controller: owns the IDLE/FILL state machine, the beat counter,
// the latched line address and the instruction-memory handshake.
module icache_direct_fill_ctrl
   import icache_direct_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 start,
   input  logic                 flush,
   input  logic                 mem_valid,
   input  logic [WORD_SIZE-1:0] miss_addr,
   output logic                 busy,
   output logic                 mem_readM,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [OFF_W-1:0]     beat,
   output logic [IDX_W-1:0]     fill_idx,
   output logic [TAG_W-1:0]     fill_tag,
   output logic                 beat_wr,
   output logic                 fill_done
);

   fill_state_t       state;
   logic [LINE_W-1:0] fill_line;
   logic              last_beat;

   assign busy        = (state == S_FILL);
   assign last_beat   = (beat == OFF_W'(LINE_WORDS - 1));
   assign beat_wr     = busy & mem_valid & ~flush;
   assign fill_done   = beat_wr & last_beat;
   assign mem_address = busy ? {fill_line, beat} : '0;
   assign fill_idx    = fill_line[IDX_W-1:0];
   assign fill_tag    = fill_line[LINE_W-1:IDX_W];

   // Fill FSM: latch the missing line, step one beat per returned word,
   // and drop back to IDLE on the last beat or when a flush aborts the fill.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         beat      <= '0;
         fill_line <= '0;
         mem_readM <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  fill_line <= miss_addr[WORD_SIZE-1:OFF_W];
                  beat      <= '0;
                  mem_readM <= 1'b1;
                  state     <= S_FILL;
               end
            end
            S_FILL: begin
               if (flush) begin
                  beat      <= '0;
                  mem_readM <= 1'b0;
                  state     <= S_IDLE;
               end else if (mem_valid) begin
                  beat <= beat + OFF_W'(1);
                  if (last_beat) begin
                     mem_readM <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
            end
            default: begin
               mem_readM <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/icache_direct.sv
// Read-only direct-mapped instruction cache: tag/valid/data arrays,
// same-cycle hit path, hit/miss counters, and the line-fill controller.
module icache_direct
   import icache_direct_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 fetch_req,
   input  logic [WORD_SIZE-1:0] fetch_addr,
   output logic [WORD_SIZE-1:0] fetch_data,
   output logic                 fetch_ready,
   input  logic                 flush,
   output logic                 mem_readM,
   output logic [WORD_SIZE-1:0] mem_address,
   input  logic [WORD_SIZE-1:0] mem_data,
   input  logic                 mem_valid,
   output logic [WORD_SIZE-1:0] hit_count,
   output logic [WORD_SIZE-1:0] miss_count
);

   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tags  [NUM_LINES];
   logic [WORD_SIZE-1:0] lines [NUM_LINES][LINE_WORDS];

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFF_W-1:0] req_off;
   logic             busy;
   logic             hit;
   logic             start;
   logic [OFF_W-1:0] beat;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             beat_wr;
   logic             fill_done;

   assign req_tag = fetch_addr[WORD_SIZE-1:OFF_W+IDX_W];
   assign req_idx = fetch_addr[OFF_W+IDX_W-1:OFF_W];
   assign req_off = fetch_addr[OFF_W-1:0];

   assign hit         = fetch_req & ~busy & valid[req_idx] & (tags[req_idx] == req_tag);
   assign start       = fetch_req & ~busy & ~hit & ~flush;
   assign fetch_ready = hit;
   assign fetch_data  = hit ? lines[req_idx][req_off] : '0;

   icache_direct_fill_ctrl u_fill (
      .Clk         (Clk),
      .Reset       (Reset),
      .start       (start),
      .flush       (flush),
      .mem_valid   (mem_valid),
      .miss_addr   (fetch_addr),
      .busy        (busy),
      .mem_readM   (mem_readM),
      .mem_address (mem_address),
      .beat        (beat),
      .fill_idx    (fill_idx),
      .fill_tag    (fill_tag),
      .beat_wr     (beat_wr),
      .fill_done   (fill_done)
   );

   // Valid bits: flush wipes everything, a starting fill hides its line,
   // and the line only becomes visible once its last beat lands.
   always_ff @(posedge Clk) begin
      if (Reset || flush) begin
         valid <= '0;
      end else begin
         if (start) begin
            valid[req_idx] <= 1'b0;
         end
         if (fill_done) begin
            valid[fill_idx] <= 1'b1;
         end
      end
   end

   // Tag and data storage is never reset; the valid bits guard it.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (beat_wr) begin
            lines[fill_idx][beat] <= mem_data;
         end
         if (fill_done) begin
            tags[fill_idx] <= fill_tag;
         end
      end
   end

   // Performance counters: every hit cycle and every started fill, wrapping.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit) begin
            hit_count <= hit_count + WORD_SIZE'(1);
         end
         if (start) begin
            miss_count <= miss_count + WORD_SIZE'(1);
         end
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Directed testbench for icache_direct: cold miss, hits, conflict eviction,
// flush, reset mid-fill, address change during fill and top-of-memory wrap.
module tb_icache_direct;

   logic        Clk;
   logic        Reset;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic [15:0] fetch_data;
   logic        fetch_ready;
   logic        flush;
   logic        mem_readM;
   logic [15:0] mem_address;
   logic [15:0] mem_data;
   logic        mem_valid;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int compared = 0;
   int mismatched = 0;

   icache_direct dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_data  (fetch_data),
      .fetch_ready (fetch_ready),
      .flush       (flush),
      .mem_readM   (mem_readM),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_valid   (mem_valid),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   // Free-running clock, period 10.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Serve a whole line from memory, one word per cycle, checking the beat addresses.
   task automatic applyStimulus(input logic [15:0] base, input logic [15:0] dbase);
      for (int b = 0; b < 4; b++) begin
         mem_valid = 1'b1;
         mem_data  = dbase + 16'(b);
         #1;
         checkOutput("fill_addr", mem_address, base + 16'(b));
         checkOutput("fill_readM", {15'd0, mem_readM}, 16'd1);
         checkOutput("fill_stall", {15'd0, fetch_ready}, 16'd0);
         tick();
      end
      mem_valid = 1'b0;
      mem_data  = 16'h0000;
   endtask

   // Ask for one address and check the combinational hit response.
   task automatic fetchHit(input logic [15:0] addr, input logic [15:0] expData);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      #1;
      checkOutput("hit_ready", {15'd0, fetch_ready}, 16'd1);
      checkOutput("hit_data", fetch_data, expData);
      checkOutput("hit_readM", {15'd0, mem_readM}, 16'd0);
      tick();
   endtask

   // Present an address that must miss, then let the miss edge pass.
   task automatic fetchMiss(input logic [15:0] addr);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      #1;
      checkOutput("miss_ready", {15'd0, fetch_ready}, 16'd0);
      checkOutput("miss_data", fetch_data, 16'h0000);
      tick();
   endtask

   // Linear directed sequence with hand-computed expectations.
   initial begin
      $display("[TB] icache_direct directed test");
      Reset = 1'b1; fetch_req = 1'b0; fetch_addr = 16'h0000; flush = 1'b0;
      mem_data = 16'h0000; mem_valid = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      #1;
      checkOutput("rst_ready", {15'd0, fetch_ready}, 16'd0);
      checkOutput("rst_data", fetch_data, 16'h0000);
      checkOutput("rst_readM", {15'd0, mem_readM}, 16'd0);
      checkOutput("rst_addr", mem_address, 16'h0000);
      checkOutput("rst_hits", hit_count, 16'd0);
      checkOutput("rst_misses", miss_count, 16'd0);

      // Cold miss on 0x0012, line 0x0010..0x0013 returns 0xA0..0xA3.
      fetchMiss(16'h0012);
      checkOutput("cold_miss_cnt", miss_count, 16'd1);
      applyStimulus(16'h0010, 16'h00A0);
      fetchHit(16'h0012, 16'h00A2);

      // Back-to-back hits in the freshly filled line.
      fetchHit(16'h0010, 16'h00A0);
      fetchHit(16'h0011, 16'h00A1);
      fetchHit(16'h0013, 16'h00A3);
      fetch_req = 1'b0;
      #1;
      checkOutput("hits_after_line", hit_count, 16'd4);
      checkOutput("miss_after_line", miss_count, 16'd1);

      // Conflict: 0x0090 shares index 4 with 0x0010 but has a different tag.
      fetchMiss(16'h0090);
      applyStimulus(16'h0090, 16'h00B0);
      fetchHit(16'h0091, 16'h00B1);
      fetchMiss(16'h0010);
      applyStimulus(16'h0010, 16'h00C0);
      fetchHit(16'h0010, 16'h00C0);
      checkOutput("conflict_misses", miss_count, 16'd3);

      // Flush after beat 1 of the 0x0020 fill.
      fetchMiss(16'h0020);
      mem_valid = 1'b1; mem_data = 16'h00D0; tick();
      mem_valid = 1'b1; mem_data = 16'h00D1; tick();
      flush = 1'b1; mem_valid = 1'b1; mem_data = 16'h00D2;
      #1;
      checkOutput("flush_readM_hold", {15'd0, mem_readM}, 16'd1);
      tick();
      flush = 1'b0; mem_valid = 1'b0;
      #1;
      checkOutput("flush_readM_drop", {15'd0, mem_readM}, 16'd0);
      checkOutput("flush_no_stale", {15'd0, fetch_ready}, 16'd0);
      tick();
      checkOutput("flush_refill_cnt", miss_count, 16'd5);
      applyStimulus(16'h0020, 16'h00E0);
      fetchHit(16'h0020, 16'h00E0);

      // Flush together with a miss: no fill, no miss counted.
      fetch_req = 1'b1; fetch_addr = 16'h0010; flush = 1'b1;
      #1;
      checkOutput("flushmiss_ready", {15'd0, fetch_ready}, 16'd0);
      tick();
      flush = 1'b0; fetch_req = 1'b0;
      #1;
      checkOutput("flushmiss_readM", {15'd0, mem_readM}, 16'd0);
      checkOutput("flushmiss_cnt", miss_count, 16'd5);
      checkOutput("flushmiss_hits", hit_count, 16'd7);

      // Top-of-memory line 0xFFFC..0xFFFF.
      fetchMiss(16'hFFFE);
      applyStimulus(16'hFFFC, 16'h00F0);
      fetchHit(16'hFFFE, 16'h00F2);
      fetchHit(16'hFFFF, 16'h00F3);

      // Reset during beat 2 of the 0x0050 fill, then a stray mem_valid.
      fetchMiss(16'h0050);
      mem_valid = 1'b1; mem_data = 16'h0050; tick();
      mem_valid = 1'b1; mem_data = 16'h0051; tick();
      Reset = 1'b1; mem_data = 16'h0052; tick();
      Reset = 1'b0; fetch_req = 1'b0; mem_valid = 1'b1; mem_data = 16'h5555;
      #1;
      checkOutput("rstmid_ready", {15'd0, fetch_ready}, 16'd0);
      checkOutput("rstmid_readM", {15'd0, mem_readM}, 16'd0);
      checkOutput("rstmid_addr", mem_address, 16'h0000);
      checkOutput("rstmid_hits", hit_count, 16'd0);
      checkOutput("rstmid_misses", miss_count, 16'd0);
      tick();
      mem_valid = 1'b0;
      #1;
      checkOutput("stray_readM", {15'd0, mem_readM}, 16'd0);

      // fetch_addr moves from 0x0030 to 0x0044 halfway through the fill.
      fetchMiss(16'h0030);
      mem_valid = 1'b1; mem_data = 16'h0070; tick();
      mem_valid = 1'b1; mem_data = 16'h0071; tick();
      fetch_addr = 16'h0044;
      mem_valid = 1'b1; mem_data = 16'h0072;
      #1;
      checkOutput("chg_addr2", mem_address, 16'h0032);
      checkOutput("chg_stall2", {15'd0, fetch_ready}, 16'd0);
      tick();
      mem_valid = 1'b1; mem_data = 16'h0073;
      #1;
      checkOutput("chg_addr3", mem_address, 16'h0033);
      tick();
      mem_valid = 1'b0;
      fetchMiss(16'h0044);
      checkOutput("chg_misses", miss_count, 16'd2);
      applyStimulus(16'h0044, 16'h0060);
      fetchHit(16'h0044, 16'h0060);
      fetchHit(16'h0032, 16'h0072);
      fetch_req = 1'b0;
      #1;
      checkOutput("final_hits", hit_count, 16'd2);
      checkOutput("final_misses", miss_count, 16'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
